// File: rtl/demux4_deser.sv
// demux4_deser: per-lane serial-to-parallel word assembly behind the 1x4 demux,
// with round-robin arbitration of completed words onto one ready/valid output.
module demux4_deser #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic [1:0]       s,
   input  logic [3:0]       y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_ch,
   output logic [3:0]       overflow
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] shift [4];
   logic [WIDTH-1:0] hold  [4];
   logic [WIDTH-1:0] word  [4];
   logic [CW-1:0]    cnt   [4];
   logic [3:0]       hold_full, done, take;
   logic [1:0]       rr_ptr, g;
   logic             found, load;

   always_comb begin
      load  = !out_valid || out_ready;
      g     = 2'd0;
      found = 1'b0;
      // descending scan so the lane closest to rr_ptr wins
      for (int i = 3; i >= 0; i--)
         if (hold_full[rr_ptr + 2'(i)]) begin
            g     = rr_ptr + 2'(i);
            found = 1'b1;
         end
      for (int k = 0; k < 4; k++) begin
         word[k] = MSB_FIRST ? {shift[k][WIDTH-2:0], y[k]} : {y[k], shift[k][WIDTH-1:1]};
         done[k] = bit_valid && s == 2'(k) && cnt[k] == CW'(WIDTH-1);
         take[k] = load && found && g == 2'(k);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            shift[k] <= '0;
            hold[k]  <= '0;
            cnt[k]   <= '0;
         end
         hold_full <= '0;
         overflow  <= '0;
         rr_ptr    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (bit_valid && s == 2'(k)) begin
               shift[k] <= word[k];
               cnt[k]   <= done[k] ? '0 : cnt[k] + 1'b1;
            end
            // a hold being drained this edge can accept the new word
            if (done[k] && (!hold_full[k] || take[k])) begin
               hold[k]      <= word[k];
               hold_full[k] <= 1'b1;
            end else if (take[k])
               hold_full[k] <= 1'b0;
            if (done[k] && hold_full[k] && !take[k])
               overflow[k] <= 1'b1;
         end
         if (load) begin
            out_valid <= found;
            if (found) begin
               out_data <= hold[g];
               out_ch   <= g;
               rr_ptr   <= g + 2'd1;
            end
         end
      end
   end
endmodule
